// File: rtl/uart_pkg.sv
// Register map and bit-index constants shared by the UART CSR/FIFO front end.
package uart_pkg;

  typedef enum logic [2:0] {
    REG_TXDATA = 3'd0,
    REG_DVSR   = 3'd1,
    REG_CTRL   = 3'd2,
    REG_RXDATA = 3'd3,
    REG_STATUS = 3'd4,
    REG_IRQ_EN = 3'd5
  } reg_idx_e;

  localparam int unsigned CTRL_TX_EN = 0;
  localparam int unsigned CTRL_RX_EN = 1;
  localparam int unsigned CTRL_STOP2 = 2;

  localparam int unsigned ST_TX_EMPTY = 0;
  localparam int unsigned ST_TX_FULL  = 1;
  localparam int unsigned ST_RX_EMPTY = 2;
  localparam int unsigned ST_RX_FULL  = 3;
  localparam int unsigned ST_TX_DONE  = 4;
  localparam int unsigned ST_TX_OVF   = 5;
  localparam int unsigned ST_RX_OVF   = 6;

  localparam int unsigned IE_TX_EMPTY = 0;
  localparam int unsigned IE_TX_DONE  = 1;
  localparam int unsigned IE_RX_AVAIL = 2;
  localparam int unsigned IE_RX_OVF   = 3;
  localparam int unsigned IE_TX_OVF   = 4;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead head; push while full is accepted only
// when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_csr_fifo.sv
// UART register front end: TX/RX FIFOs, baud/frame control, sticky W1C
// status and per-source interrupt enables.
module uart_csr_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DVSR_W   = 11,
  parameter int unsigned DVSR_RST = 651,
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [4:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              tx_done,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DVSR_W-1:0] dvsr,
  output logic              stop2,
  output logic              tx_irq,
  output logic              rx_irq
);

  localparam int unsigned TX_CW = $clog2(TX_DEPTH+1);
  localparam int unsigned RX_CW = $clog2(RX_DEPTH+1);

  logic [2:0]        word;
  logic              tx_en, rx_en, stop2_q;
  logic [4:0]        irq_en;
  logic [DVSR_W-1:0] dvsr_q;
  logic              tx_done_s, tx_ovf, rx_ovf;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [DATA_W-1:0] rx_head;
  logic [TX_CW-1:0]  tx_count;
  logic [RX_CW-1:0]  rx_count;
  logic              tx_push, tx_pop, rx_push, rx_pop, st_we;
  logic              unused_bits;

  assign word     = addr[4:2];
  assign tx_valid = tx_en && !tx_empty;
  assign tx_push  = we && (word == REG_TXDATA);
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_push  = rx_valid && rx_en;
  assign rx_pop   = re && (word == REG_RXDATA) && !rx_empty;
  assign st_we    = we && (word == REG_STATUS);

  assign dvsr  = dvsr_q;
  assign stop2 = stop2_q;

  assign tx_irq = (irq_en[IE_TX_EMPTY] && tx_empty) ||
                  (irq_en[IE_TX_DONE]  && tx_done_s) ||
                  (irq_en[IE_TX_OVF]   && tx_ovf);
  assign rx_irq = (irq_en[IE_RX_AVAIL] && !rx_empty) ||
                  (irq_en[IE_RX_OVF]   && rx_ovf);

  assign unused_bits = ^{addr[1:0], wdata, tx_count, rx_count};

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (wdata[DATA_W-1:0]),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_data),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      dvsr_q    <= DVSR_W'(DVSR_RST);
      tx_en     <= 1'b0;
      rx_en     <= 1'b0;
      stop2_q   <= 1'b0;
      irq_en    <= '0;
      tx_done_s <= 1'b0;
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
    end else begin
      if (we) begin
        case (word)
          REG_DVSR:   dvsr_q <= wdata[DVSR_W-1:0];
          REG_CTRL: begin
            tx_en   <= wdata[CTRL_TX_EN];
            rx_en   <= wdata[CTRL_RX_EN];
            stop2_q <= wdata[CTRL_STOP2];
          end
          REG_IRQ_EN: irq_en <= wdata[4:0];
          default:    ;
        endcase
      end
      // A new event in the same cycle as its W1C keeps the bit set.
      tx_done_s <= tx_done || (tx_done_s && !(st_we && wdata[ST_TX_DONE]));
      tx_ovf    <= (tx_push && tx_full && !tx_pop) ||
                   (tx_ovf && !(st_we && wdata[ST_TX_OVF]));
      rx_ovf    <= (rx_push && rx_full && !rx_pop) ||
                   (rx_ovf && !(st_we && wdata[ST_RX_OVF]));
    end
  end

  always_comb begin
    rdata = '0;
    case (word)
      REG_TXDATA: rdata[31] = tx_full;
      REG_DVSR:   rdata[DVSR_W-1:0] = dvsr_q;
      REG_CTRL: begin
        rdata[CTRL_TX_EN] = tx_en;
        rdata[CTRL_RX_EN] = rx_en;
        rdata[CTRL_STOP2] = stop2_q;
      end
      REG_RXDATA: begin
        rdata[31]          = rx_empty;
        rdata[DATA_W-1:0]  = rx_head;
      end
      REG_STATUS: begin
        rdata[ST_TX_EMPTY] = tx_empty;
        rdata[ST_TX_FULL]  = tx_full;
        rdata[ST_RX_EMPTY] = rx_empty;
        rdata[ST_RX_FULL]  = rx_full;
        rdata[ST_TX_DONE]  = tx_done_s;
        rdata[ST_TX_OVF]   = tx_ovf;
        rdata[ST_RX_OVF]   = rx_ovf;
      end
      REG_IRQ_EN: rdata[4:0] = irq_en;
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_uart_csr_fifo.sv
// Bench for uart_csr_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_csr_fifo;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, we, re, tx_ready, tx_done, rx_valid;
  logic [4:0]  addr;
  logic [31:0] wdata, rdata;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, stop2, tx_irq, rx_irq;
  logic [10:0] dvsr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [7:0]  m_txq[$];
  logic [7:0]  m_rxq[$];
  logic [10:0] m_dvsr;
  logic        m_tx_en, m_rx_en, m_stop2;
  logic [4:0]  m_ie;
  logic        m_done, m_txovf, m_rxovf;
  bit          m_valid = 1'b0;

  uart_csr_fifo #(
    .DATA_W(8), .DVSR_W(11), .DVSR_RST(651), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .rx_data(rx_data), .rx_valid(rx_valid), .dvsr(dvsr),
    .stop2(stop2), .tx_irq(tx_irq), .rx_irq(rx_irq)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
    logic [31:0] r;
    r = '0;
    case (a[4:2])
      3'd0: r[31] = (m_txq.size() == DEPTH);
      3'd1: r[10:0] = m_dvsr;
      3'd2: r[2:0] = {m_stop2, m_rx_en, m_tx_en};
      3'd3: begin
        r[31] = (m_rxq.size() == 0);
        if (m_rxq.size() != 0) r[7:0] = m_rxq[0];
      end
      3'd4: r[6:0] = {m_rxovf, m_txovf, m_done, m_rxq.size() == DEPTH,
                      m_rxq.size() == 0, m_txq.size() == DEPTH, m_txq.size() == 0};
      3'd5: r[4:0] = m_ie;
      default: ;
    endcase
    return r;
  endfunction

  task automatic check_all();
    logic [31:0] msk;
    logic        exp_txv;
    if (m_valid) begin
      exp_txv = m_tx_en && (m_txq.size() != 0);
      chk("tx_valid", 32'(tx_valid), 32'(exp_txv));
      if (exp_txv) chk("tx_data", 32'(tx_data), 32'(m_txq[0]));
      chk("dvsr", 32'(dvsr), 32'(m_dvsr));
      chk("stop2", 32'(stop2), 32'(m_stop2));
      chk("tx_irq", 32'(tx_irq), 32'((m_ie[0] && m_txq.size() == 0) ||
                                      (m_ie[1] && m_done) || (m_ie[4] && m_txovf)));
      chk("rx_irq", 32'(rx_irq), 32'((m_ie[2] && m_rxq.size() != 0) ||
                                      (m_ie[3] && m_rxovf)));
      msk = (addr[4:2] == 3'd3 && m_rxq.size() == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      chk("rdata", rdata & msk, m_rdata(addr) & msk);
    end
  endtask

  task automatic model_step();
    bit tx_pop, tx_push, rx_pop, rx_push, st_we;
    int txn, rxn;
    if (rst) begin
      m_txq.delete();
      m_rxq.delete();
      m_dvsr  = 11'd651;
      m_tx_en = 0; m_rx_en = 0; m_stop2 = 0;
      m_ie    = '0;
      m_done  = 0; m_txovf = 0; m_rxovf = 0;
      m_valid = 1;
    end else if (m_valid) begin
      txn     = m_txq.size();
      rxn     = m_rxq.size();
      tx_pop  = m_tx_en && txn > 0 && tx_ready;
      tx_push = we && addr[4:2] == 3'd0;
      rx_pop  = re && addr[4:2] == 3'd3 && rxn > 0;
      rx_push = rx_valid && m_rx_en;
      st_we   = we && addr[4:2] == 3'd4;
      if (st_we && wdata[4]) m_done  = 0;
      if (st_we && wdata[5]) m_txovf = 0;
      if (st_we && wdata[6]) m_rxovf = 0;
      if (tx_done) m_done = 1;
      if (tx_pop) void'(m_txq.pop_front());
      if (tx_push) begin
        if (txn < DEPTH || tx_pop) m_txq.push_back(wdata[7:0]);
        else m_txovf = 1;
      end
      if (rx_pop) void'(m_rxq.pop_front());
      if (rx_push) begin
        if (rxn < DEPTH || rx_pop) m_rxq.push_back(rx_data);
        else m_rxovf = 1;
      end
      if (we && addr[4:2] == 3'd1) m_dvsr = wdata[10:0];
      if (we && addr[4:2] == 3'd2) {m_stop2, m_rx_en, m_tx_en} = wdata[2:0];
      if (we && addr[4:2] == 3'd5) m_ie = wdata[4:0];
    end
  endtask

  task automatic tick();
    #1;
    check_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; we = 0; re = 0; tx_ready = 0; tx_done = 0; rx_valid = 0;
    addr = '0; wdata = '0; rx_data = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1;
    tick();
    we = 0;
  endtask

  task automatic peek(input string name, input logic [4:0] a,
                      input logic [31:0] exp, input logic [31:0] msk);
    addr = a; re = 0; we = 0;
    #1;
    chk(name, rdata & msk, exp & msk);
    tick();
  endtask

  task automatic rd_pop(input string name, input logic [31:0] exp);
    addr = 5'd12; re = 1;
    #1;
    chk(name, rdata, exp);
    tick();
    re = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;

    // Reset state
    chk("rst_dvsr_out", 32'(dvsr), 32'd651);
    chk("rst_tx_irq", 32'(tx_irq), 32'd0);
    chk("rst_rx_irq", 32'(rx_irq), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    peek("rst_status", 5'd16, 32'h5, '1);
    peek("rst_dvsr_reg", 5'd4, 32'd651, '1);

    // TX ordering
    wr(5'd8, 32'h1);
    wr(5'd0, 32'h41);
    wr(5'd0, 32'h42);
    wr(5'd0, 32'h43);
    for (int i = 0; i < 3; i++) begin
      tx_ready = 1;
      chk("tx_seq", 32'(tx_data), 32'h41 + 32'(i));
      tick();
      tx_ready = 0;
    end
    chk("tx_drained_valid", 32'(tx_valid), 32'd0);
    peek("tx_drained_status", 5'd16, 32'h5, '1);

    // TX overflow with engine disabled
    wr(5'd8, 32'h0);
    for (int i = 0; i < 9; i++) wr(5'd0, 32'h60 + 32'(i));
    peek("tx_ovf_status", 5'd16, 32'h26, '1);
    peek("txdata_full", 5'd0, 32'h8000_0000, '1);
    wr(5'd16, 32'h20);
    peek("tx_ovf_w1c", 5'd16, 32'h06, '1);
    wr(5'd8, 32'h1);
    for (int i = 0; i < 8; i++) begin
      tx_ready = 1;
      chk("tx_ovf_seq", 32'(tx_data), 32'h60 + 32'(i));
      tick();
      tx_ready = 0;
    end
    peek("tx_ovf_drained", 5'd16, 32'h5, '1);

    // RX single character and interrupt
    wr(5'd20, 32'h4);
    wr(5'd8, 32'h2);
    rx_valid = 1; rx_data = 8'h55;
    tick();
    rx_valid = 0;
    chk("rx_irq_set", 32'(rx_irq), 32'd1);
    rd_pop("rx_read", 32'h55);
    peek("rx_empty_read", 5'd12, 32'h8000_0000, 32'h8000_0000);
    chk("rx_irq_clr", 32'(rx_irq), 32'd0);

    // RX full, overflow, then push with simultaneous pop
    for (int i = 0; i < 8; i++) begin
      rx_valid = 1; rx_data = 8'h70 + 8'(i);
      tick();
    end
    rx_valid = 0;
    peek("rx_full_status", 5'd16, 32'h9, '1);
    rx_valid = 1; rx_data = 8'hEE;
    tick();
    rx_valid = 0;
    peek("rx_ovf_status", 5'd16, 32'h49, '1);
    wr(5'd16, 32'h40);
    peek("rx_ovf_w1c", 5'd16, 32'h09, '1);
    addr = 5'd12; re = 1; rx_valid = 1; rx_data = 8'h99;
    #1;
    chk("rx_simul_head", rdata, 32'h70);
    tick();
    idle();
    peek("rx_simul_status", 5'd16, 32'h09, '1);
    for (int i = 1; i < 8; i++) rd_pop("rx_drain", 32'h70 + 32'(i));
    rd_pop("rx_drain_last", 32'h99);
    peek("rx_drained", 5'd12, 32'h8000_0000, 32'h8000_0000);

    // Sticky set beats W1C in the same cycle
    tx_done = 1;
    wr(5'd16, 32'h10);
    tx_done = 0;
    peek("done_set_wins", 5'd16, 32'h15, '1);
    wr(5'd16, 32'h10);
    peek("done_cleared", 5'd16, 32'h05, '1);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      logic [2:0] w;
      rst = ($urandom_range(0, 399) == 0);
      we  = ($urandom_range(0, 3) == 0);
      re  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) w = 3'($urandom_range(0, 7));
      else w = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'd3;
      addr     = {w, 2'($urandom)};
      wdata    = $urandom;
      tx_ready = ($urandom_range(0, 3) == 0);
      tx_done  = ($urandom_range(0, 9) == 0);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
      tick();
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
